fetch_queue: RTL and testbench

Instruction fetch front end sitting directly upstream of the text (instruction) memory. It owns the fetch PC, drives the word address into the combinational-read text memory, captures the returned instruction word with its PC into a small FIFO, and presents instructions to the decode stage through a valid/ready handshake. Redirects from branches and jumps flush the queue and restart fetch at the new target.

---
 rtl/fetch_queue.sv | 101 ++++++++++
 tb/tb_fetch_queue.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, reads the combinational text memory, and
// buffers {word, pc} pairs in a small FIFO presented to decode through a valid/ready handshake.
`ifndef TEXT_BITS
`define TEXT_BITS 16
`endif

module fetch_queue #(
   parameter int unsigned TEXT_BITS = `TEXT_BITS,
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = 32'h0040_0000
) (
   input  logic                 clock,
   input  logic                 reset,
   output logic [TEXT_BITS-3:0] text_address,
   input  logic [31:0]          text_q,
   input  logic                 redirect,
   input  logic [31:0]          redirect_pc,
   output logic                 inst_valid,
   input  logic                 inst_ready,
   output logic [31:0]          inst,
   output logic [31:0]          inst_pc
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam logic [PtrW:0] CountFull = (PtrW + 1)'(DEPTH);

   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW:0]   count_q, count_d;
   logic [31:0]     word_q [DEPTH];
   logic [31:0]     pc_q   [DEPTH];

   logic pop;
   logic push;
   logic unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // Head outputs come only from registered state, never from the inputs.
   assign inst_valid   = (count_q != '0);
   assign inst         = word_q[rd_ptr_q];
   assign inst_pc      = pc_q[rd_ptr_q];
   assign text_address = fetch_pc_q[TEXT_BITS-1:2];

   assign pop  = inst_valid & inst_ready;
   assign push = ~redirect & ((count_q < CountFull) | pop);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (redirect) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_d = count_q + 1'b1;
         end else if (pop && !push) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            word_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else if (push) begin
         word_q[wr_ptr_q] <= text_q;
         pc_q[wr_ptr_q]   <= fetch_pc_q;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a reference queue of expected {word, pc} pairs is
// filled as fetches are modelled and drained as the consumer handshakes.
module tb_fetch_queue;

   localparam int unsigned TB_TEXT_BITS = 16;
   localparam int unsigned DEPTH        = 4;
   localparam logic [31:0] RESET_PC     = 32'h0040_0000;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } ent_t;

   logic                    clock;
   logic                    reset;
   logic [TB_TEXT_BITS-3:0] text_address;
   logic [31:0]             text_q;
   logic                    redirect;
   logic [31:0]             redirect_pc;
   logic                    inst_valid;
   logic                    inst_ready;
   logic [31:0]             inst;
   logic [31:0]             inst_pc;

   int          checks;
   int          failures;
   ent_t        exp_q[$];
   logic [31:0] model_pc;

   fetch_queue #(
      .TEXT_BITS(TB_TEXT_BITS),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .text_address(text_address),
      .text_q      (text_q),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst        (inst),
      .inst_pc     (inst_pc)
   );

   // Text memory: word at word address a is A000_0000 + a.
   assign text_q = 32'hA000_0000 + {18'b0, text_address};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] word_at(input logic [31:0] pc);
      return 32'hA000_0000 + {18'b0, pc[15:2]};
   endfunction

   // Advance the reference model with the current inputs, then cross one rising edge.
   task automatic tick();
      logic pop;
      logic push;
      pop  = (exp_q.size() != 0) && inst_ready;
      push = !redirect && ((exp_q.size() < int'(DEPTH)) || pop);
      if (pop) void'(exp_q.pop_front());
      if (redirect) begin
         exp_q.delete();
         model_pc = {redirect_pc[31:2], 2'b00};
      end else if (push) begin
         exp_q.push_back({word_at(model_pc), model_pc});
         model_pc = model_pc + 32'd4;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clock);
      reset = 1'b0;
      exp_q.delete();
      model_pc = RESET_PC;
      #2;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      redirect = 1'b0;
      redirect_pc = '0;
      inst_ready = 1'b0;
      exp_q.delete();
      model_pc = RESET_PC;
      #3;
      checks++;
      if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs: got valid=%b inst=%h pc=%h, expected 0/0/0",
                  inst_valid, inst, inst_pc);
      end
      checks++;
      if (text_address !== RESET_PC[TB_TEXT_BITS-1:2]) begin
         failures++;
         $display("FAIL reset_address: got %h expected %h", text_address,
                  RESET_PC[TB_TEXT_BITS-1:2]);
      end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_streaming();
      inst_ready = 1'b1;
      checks++;
      if (inst_valid !== 1'b0) begin
         failures++;
         $display("FAIL stream_cycle0: got valid=%b expected 0", inst_valid);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (exp_q.size() == 0 || inst_valid !== 1'b1 || inst_pc !== exp_q[0].pc ||
             inst !== exp_q[0].word || inst_pc !== RESET_PC + 32'(4 * i) ||
             inst !== 32'hA000_0000 + 32'(i)) begin
            failures++;
            $display("FAIL stream_%0d: got valid=%b inst=%h pc=%h, expected 1/%h/%h", i,
                     inst_valid, inst, inst_pc, 32'hA000_0000 + 32'(i), RESET_PC + 32'(4 * i));
         end
      end
   endtask

   task automatic test_back_pressure();
      apply_reset();
      inst_ready = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      checks++;
      if (text_address !== 14'h0004 || inst_valid !== 1'b1 || inst_pc !== RESET_PC) begin
         failures++;
         $display("FAIL bp_hold: got addr=%h valid=%b pc=%h, expected 0004/1/%h",
                  text_address, inst_valid, inst_pc, RESET_PC);
      end
      inst_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (exp_q.size() == 0 || inst_valid !== 1'b1 || inst_pc !== exp_q[0].pc ||
             inst !== exp_q[0].word || inst_pc !== RESET_PC + 32'(4 * i)) begin
            failures++;
            $display("FAIL bp_drain_%0d: got valid=%b inst=%h pc=%h, expected pc=%h", i,
                     inst_valid, inst, inst_pc, RESET_PC + 32'(4 * i));
         end
         tick();
      end
   endtask

   task automatic test_full_pop();
      apply_reset();
      inst_ready = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      checks++;
      if (text_address !== 14'h0005 || inst_valid !== 1'b1 || inst_pc !== RESET_PC + 32'd4 ||
          exp_q.size() == 0 || inst !== exp_q[0].word) begin
         failures++;
         $display("FAIL full_pop: got addr=%h valid=%b pc=%h, expected 0005/1/%h",
                  text_address, inst_valid, inst_pc, RESET_PC + 32'd4);
      end
      tick();
      checks++;
      if (text_address !== 14'h0005) begin
         failures++;
         $display("FAIL full_pop_still_full: got addr=%h expected 0005", text_address);
      end
   endtask

   task automatic test_redirect_flush();
      apply_reset();
      inst_ready = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      redirect = 1'b1;
      redirect_pc = 32'h0040_0102;
      tick();
      redirect = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || text_address !== 14'h0040) begin
         failures++;
         $display("FAIL flush_empty: got valid=%b addr=%h, expected 0/0040",
                  inst_valid, text_address);
      end
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0040_0100 || inst !== 32'hA000_0040) begin
         failures++;
         $display("FAIL flush_target: got valid=%b inst=%h pc=%h, expected 1/a0000040/00400100",
                  inst_valid, inst, inst_pc);
      end
      inst_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (exp_q.size() == 0 || inst_valid !== 1'b1 || inst_pc !== exp_q[0].pc ||
             inst !== exp_q[0].word || inst_pc !== 32'h0040_0100 + 32'(4 * i)) begin
            failures++;
            $display("FAIL flush_drain_%0d: got valid=%b pc=%h, expected pc=%h", i,
                     inst_valid, inst_pc, 32'h0040_0100 + 32'(4 * i));
         end
         tick();
      end
   endtask

   task automatic test_redirect_pop();
      apply_reset();
      inst_ready = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      inst_ready = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h0040_0200;
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== RESET_PC || inst !== 32'hA000_0000) begin
         failures++;
         $display("FAIL rpop_handshake: got valid=%b inst=%h pc=%h, expected 1/a0000000/%h",
                  inst_valid, inst, inst_pc, RESET_PC);
      end
      tick();
      redirect = 1'b0;
      checks++;
      if (inst_valid !== 1'b0) begin
         failures++;
         $display("FAIL rpop_empty: got valid=%b expected 0", inst_valid);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (exp_q.size() == 0 || inst_valid !== 1'b1 || inst_pc !== exp_q[0].pc ||
             inst !== exp_q[0].word || inst_pc !== 32'h0040_0200 + 32'(4 * i)) begin
            failures++;
            $display("FAIL rpop_target_%0d: got valid=%b pc=%h, expected pc=%h", i,
                     inst_valid, inst_pc, 32'h0040_0200 + 32'(4 * i));
         end
         tick();
      end
   endtask

   task automatic test_wrap();
      inst_ready = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFF;
      tick();
      redirect = 1'b0;
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst !== 32'hA000_3FFF) begin
         failures++;
         $display("FAIL wrap_top: got valid=%b inst=%h pc=%h, expected 1/a0003fff/fffffffc",
                  inst_valid, inst, inst_pc);
      end
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'hA000_0000 ||
          exp_q.size() == 0 || inst_pc !== exp_q[0].pc) begin
         failures++;
         $display("FAIL wrap_zero: got valid=%b inst=%h pc=%h, expected 1/a0000000/00000000",
                  inst_valid, inst, inst_pc);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      inst_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      #2;
      reset = 1'b0;
      exp_q.delete();
      model_pc = RESET_PC;
      #1;
      checks++;
      if (inst_valid !== 1'b0 || inst_pc !== 32'h0 || inst !== 32'h0 ||
          text_address !== RESET_PC[TB_TEXT_BITS-1:2]) begin
         failures++;
         $display("FAIL async_reset: got valid=%b inst=%h pc=%h addr=%h, expected 0/0/0/%h",
                  inst_valid, inst, inst_pc, text_address, RESET_PC[TB_TEXT_BITS-1:2]);
      end
      #1;
      reset = 1'b1;
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== RESET_PC || exp_q.size() == 0 ||
          inst !== exp_q[0].word) begin
         failures++;
         $display("FAIL async_restart: got valid=%b pc=%h, expected 1/%h",
                  inst_valid, inst_pc, RESET_PC);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_streaming();
      test_back_pressure();
      test_full_pop();
      test_redirect_flush();
      test_redirect_pop();
      test_wrap();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
